pipe_exe: RTL and testbench
===========================

PIPE_EXE -- requirements
Module: pipe_exe

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: clr  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ewreg, em2reg, ewmem, ealuimm, eshift, ejal  in  1 each  E-stage controls from D/E register.
REQ-004 SHALL have ports: ealuc  in  4  ALU op; ea, eb, eimm, epc4  in  32 each  operands, immediate, PC+4; ern  in  5  destination register.
REQ-005 SHALL have ports: mwreg, mm2reg, mwmem  out  1 each; malu, mb  out  32 each; mrn  out  5 (registered E/M outputs).
REQ-006 SHALL have ports: ern0  out  5  effective destination; ealu  out  32  E result; estall  out  1  stall request to PC, F/D and D/E registers (all combinational).

Function
REQ-007 SHALL select alua = eshift ? zero-extended eimm[10:6] : ea; alub = ealuimm ? eimm : eb.
REQ-008 SHALL decode ealuc: x000 add, x100 sub, x001 and, x101 or, x010 xor, x110 lui (alub[15:0] followed by 16 zeros), 0011 sll, 0111 srl, 1111 sra, 1011 mul; shift amount alub shifted by alua[4:0].
REQ-009 SHALL wrap add/sub/mul modulo 2^32; no overflow trap; mul yields low 32 bits of the product.
REQ-010 SHALL drive ealu = ejal ? epc4 + 4 : ALU result; ern0 = ejal ? 31 : ern.
REQ-011 SHALL, for non-mul ops, register mwreg, mm2reg, mwmem, malu(=ealu), mb(=eb), mrn(=ern0) on every rising edge (1-cycle latency).
REQ-012 SHALL execute mul with a shift-add FSM: IDLE, BUSY, DONE.
REQ-013 IDLE with ealuc=1011: SHALL load operands and clear the 5-bit iteration counter, go BUSY, and assert estall.
REQ-014 BUSY: SHALL perform one iteration per cycle for exactly 32 cycles, then go DONE; estall SHALL remain 1.
REQ-015 DONE: SHALL present the product on ealu, deassert estall, register the product into E/M like REQ-011, and return to IDLE.
REQ-016 A mul SHALL occupy E for exactly 34 cycles (1 IDLE + 32 BUSY + 1 DONE); upstream SHALL hold inputs stable while estall=1.
REQ-017 While estall=1, SHALL load a bubble into E/M: mwreg=0, mwmem=0, mm2reg=0; malu, mb and mrn don't-care.
REQ-018 An instruction entering E on the DONE->IDLE edge SHALL be processed normally, including back-to-back mul (re-enters BUSY).
REQ-019 estall SHALL be 0 whenever the FSM is IDLE and ealuc is not 1011.

Reset
REQ-020 clr=1 at a rising edge SHALL set FSM to IDLE, counter and multiplier registers to 0, and mwreg, mm2reg, mwmem, malu, mb, mrn to 0.
REQ-021 clr asserted mid-mul SHALL abort the mul with no E/M write; estall SHALL be 0 in the cycle following reset if ealuc is not 1011.

Structure
REQ-022 SHALL place ALU op codes (ALU_ADD ... ALU_MUL) and the FSM state encoding in shared package pipe_pkg.
REQ-023 SHALL implement the iterative multiplier as sub-module mul32_seq: start, operands in; busy, done, 32-bit product out.

Verification
REQ-024 add: ea=5, eb=7, ealuc=0000, ewreg=1, ern=3 -> next edge malu=12, mrn=3, mwreg=1, estall=0.
REQ-025 sra: eimm[10:6]=4, eshift=1, eb=0x80000000, ealuc=1111 -> malu=0xF8000000.
REQ-026 jal: ejal=1, epc4=0x100, ern=0 -> malu=0x104, mrn=31.
REQ-027 mul: ea=7, eb=6, ealuc=1011, ewreg=1 -> estall=1 for 33 cycles; mwreg=0 throughout; 34th edge malu=42, mwreg=1.
REQ-028 mul: 0xFFFFFFFF x 0xFFFFFFFF -> malu=1; then a back-to-back mul 3 x 3 -> malu=9 after a further 34 cycles.
REQ-029 Reset: clr pulsed at BUSY cycle 10 -> FSM IDLE, all E/M outputs 0, no product written; a following add executes in 1 cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, the
// multiplier FSM state encoding and small helpers.
package pipe_pkg;

   // ALU operation codes (canonical encodings; the x-prefixed ops also
   // accept ealuc[3]=1 in the decoder)
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1011;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   // Register number written by jal
   localparam logic [4:0] JAL_RN = 5'd31;

   // Last iteration index of the 32-step shift-add multiplier
   localparam logic [4:0] MUL_LAST_ITER = 5'd31;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // Upper-immediate: low half of the operand moved to the top
   function automatic logic [31:0] lui_value(input logic [31:0] b);
      return {b[15:0], 16'h0000};
   endfunction

endpackage

// File: rtl/mul32_seq.sv
// Iterative 32x32 -> low-32 shift-add multiplier.
// IDLE accepts start, BUSY runs exactly 32 iterations, DONE presents the
// product for one cycle and returns to IDLE.
module mul32_seq
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   mul_state_t  state_reg, state_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic [31:0] mcand_reg, mcand_next;
   logic [31:0] mplier_reg, mplier_next;
   logic [31:0] acc_reg, acc_next;
   logic [31:0] addend;

   // Partial product of this iteration: multiplicand gated by the current multiplier LSB
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_addend
         assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
      end
   endgenerate

   // State and datapath registers; reset aborts any multiply in progress
   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg  <= MUL_IDLE;
         cnt_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         acc_reg    <= acc_next;
      end
   end

   // Next-state and iteration logic
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      acc_next    = acc_reg;
      case (state_reg)
         MUL_IDLE: begin
            if (start) begin
               mcand_next  = a;
               mplier_next = b;
               acc_next    = '0;
               cnt_next    = '0;
               state_next  = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            acc_next    = acc_reg + addend;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 5'd1;
            if (cnt_reg == MUL_LAST_ITER) begin
               state_next = MUL_DONE;
            end
         end
         MUL_DONE: begin
            state_next = MUL_IDLE;
         end
         default: begin
            state_next = MUL_IDLE;
         end
      endcase
   end

   assign busy    = (state_reg == MUL_BUSY);
   assign done    = (state_reg == MUL_DONE);
   assign product = acc_reg;

endmodule

// File: rtl/pipe_exe.sv
// Execute stage: operand selection, ALU, jal link value, iterative
// multiplier with pipeline stall, and the E/M pipeline register.
module pipe_exe
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic        ewmem,
   input  logic        ealuimm,
   input  logic        eshift,
   input  logic        ejal,
   input  logic [3:0]  ealuc,
   input  logic [31:0] ea,
   input  logic [31:0] eb,
   input  logic [31:0] eimm,
   input  logic [31:0] epc4,
   input  logic [4:0]  ern,
   output logic        mwreg,
   output logic        mm2reg,
   output logic        mwmem,
   output logic [31:0] malu,
   output logic [31:0] mb,
   output logic [4:0]  mrn,
   output logic [4:0]  ern0,
   output logic [31:0] ealu,
   output logic        estall
);

   logic [31:0] alua, alub;
   logic [4:0]  shamt;
   logic [31:0] alu_res;
   logic        mul_start, mul_busy, mul_done;
   logic [31:0] mul_prod;

   logic        mwreg_reg, mm2reg_reg, mwmem_reg;
   logic [31:0] malu_reg, mb_reg;
   logic [4:0]  mrn_reg;

   assign alua  = eshift  ? {27'd0, eimm[10:6]} : ea;
   assign alub  = ealuimm ? eimm : eb;
   assign shamt = alua[4:0];

   assign mul_start = (ealuc == ALU_MUL);

   mul32_seq u_mul (
      .clk     (clk),
      .clr     (clr),
      .start   (mul_start),
      .a       (alua),
      .b       (alub),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Stall while a multiply is being accepted or iterating; the DONE cycle releases upstream
   assign estall = mul_busy | (mul_start & ~mul_done);

   // ALU decode: ealuc[1:0]=11 selects the shift/mul group, otherwise ealuc[3] is ignored
   always_comb begin
      alu_res = '0;
      if (ealuc[1:0] == 2'b11) begin
         case (ealuc[3:2])
            2'b00:   alu_res = alub << shamt;
            2'b01:   alu_res = alub >> shamt;
            2'b11:   alu_res = 32'($signed(alub) >>> shamt);
            default: alu_res = mul_prod;
         endcase
      end else begin
         case (ealuc[2:0])
            3'b000:  alu_res = alua + alub;
            3'b100:  alu_res = alua - alub;
            3'b001:  alu_res = alua & alub;
            3'b101:  alu_res = alua | alub;
            3'b010:  alu_res = alua ^ alub;
            3'b110:  alu_res = lui_value(alub);
            default: alu_res = '0;
         endcase
      end
   end

   assign ealu = ejal ? (epc4 + 32'd4) : alu_res;
   assign ern0 = ejal ? JAL_RN : ern;

   // E/M pipeline register; a stalled cycle inserts a bubble by clearing the write enables
   always_ff @(posedge clk) begin
      if (clr) begin
         mwreg_reg  <= 1'b0;
         mm2reg_reg <= 1'b0;
         mwmem_reg  <= 1'b0;
         malu_reg   <= '0;
         mb_reg     <= '0;
         mrn_reg    <= '0;
      end else begin
         mwreg_reg  <= ewreg  & ~estall;
         mm2reg_reg <= em2reg & ~estall;
         mwmem_reg  <= ewmem  & ~estall;
         malu_reg   <= ealu;
         mb_reg     <= eb;
         mrn_reg    <= ern0;
      end
   end

   assign mwreg  = mwreg_reg;
   assign mm2reg = mm2reg_reg;
   assign mwmem  = mwmem_reg;
   assign malu   = malu_reg;
   assign mb     = mb_reg;
   assign mrn    = mrn_reg;

endmodule

// File: tb/tb_pipe_exe.sv
// Self-checking bench for pipe_exe: directed cases plus random ALU and
// multiply transactions checked against a behavioural model.
module tb_pipe_exe;

   logic        clk;
   logic        clr;
   logic        ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
   logic [3:0]  ealuc;
   logic [31:0] ea, eb, eimm, epc4;
   logic [4:0]  ern;
   logic        mwreg, mm2reg, mwmem;
   logic [31:0] malu, mb;
   logic [4:0]  mrn;
   logic [4:0]  ern0;
   logic [31:0] ealu;
   logic        estall;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   pipe_exe dut (
      .clk     (clk),
      .clr     (clr),
      .ewreg   (ewreg),
      .em2reg  (em2reg),
      .ewmem   (ewmem),
      .ealuimm (ealuimm),
      .eshift  (eshift),
      .ejal    (ejal),
      .ealuc   (ealuc),
      .ea      (ea),
      .eb      (eb),
      .eimm    (eimm),
      .epc4    (epc4),
      .ern     (ern),
      .mwreg   (mwreg),
      .mm2reg  (mm2reg),
      .mwmem   (mwmem),
      .malu    (malu),
      .mb      (mb),
      .mrn     (mrn),
      .ern0    (ern0),
      .ealu    (ealu),
      .estall  (estall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Behavioural model of the ALU result from the operation table
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      int unsigned sh;
      sh = x % 32;
      case (op)
         4'd0, 4'd8:   return x + y;
         4'd4, 4'd12:  return x - y;
         4'd1, 4'd9:   return x & y;
         4'd5, 4'd13:  return x | y;
         4'd2, 4'd10:  return x ^ y;
         4'd6, 4'd14:  return y * 32'd65536;
         4'd3:         return y << sh;
         4'd7:         return y >> sh;
         4'd15:        return 32'($signed(y) >>> sh);
         default:      return x * y;
      endcase
   endfunction

   function automatic logic [31:0] ref_ealu();
      logic [31:0] x, y;
      x = eshift  ? ((eimm >> 6) % 32) : ea;
      y = ealuimm ? eimm : eb;
      if (ejal) return epc4 + 32'd4;
      return ref_alu(ealuc, x, y);
   endfunction

   task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic [4:0] rn,
                         input logic wr, input logic m2r, input logic wm,
                         input logic aimm, input logic sh, input logic jal);
      ealuc = op; ea = a; eb = b; eimm = imm; epc4 = pc4; ern = rn;
      ewreg = wr; em2reg = m2r; ewmem = wm; ealuimm = aimm; eshift = sh; ejal = jal;
   endtask

   // Single-cycle op: check combinational outputs, then the E/M register after one edge
   task automatic run_single(input string tag);
      logic [31:0] exp_alu;
      logic [4:0]  exp_rn;
      logic        w, m2, wm;
      logic [31:0] b;
      exp_alu = ref_ealu();
      exp_rn  = ejal ? 5'd31 : ern;
      w = ewreg; m2 = em2reg; wm = ewmem; b = eb;
      #1;
      check({tag, "_estall"}, 32'(estall), 32'd0);
      check({tag, "_ealu"}, ealu, exp_alu);
      @(posedge clk); #1;
      check({tag, "_malu"}, malu, exp_alu);
      check({tag, "_mrn"}, 32'(mrn), 32'(exp_rn));
      check({tag, "_ctl"}, {29'd0, mwreg, mm2reg, mwmem}, {29'd0, w, m2, wm});
      check({tag, "_mb"}, mb, b);
      txn++;
      $display("txn %0d %s op=%h ealu=0x%08h malu=0x%08h mrn=%0d", txn, tag, ealuc,
               exp_alu, malu, mrn);
   endtask

   // Multiply: 33 stalled cycles with bubbles, product written at the 34th edge
   task automatic run_mul(input string tag);
      logic [31:0] exp_p;
      int          n;
      logic        w;
      exp_p = ref_ealu();
      w = ewreg;
      #1;
      check({tag, "_stall0"}, 32'(estall), 32'd1);
      n = 1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         check({tag, "_bubble"}, {29'd0, mwreg, mm2reg, mwmem}, 32'd0);
         if (!estall) break;
         n++;
      end
      check({tag, "_stall_cycles"}, 32'(n), 32'd33);
      check({tag, "_ealu_done"}, ealu, exp_p);
      @(posedge clk); #1;
      check({tag, "_malu"}, malu, exp_p);
      check({tag, "_mwreg"}, 32'(mwreg), 32'(w));
      check({tag, "_mrn"}, 32'(mrn), 32'(ern));
      txn++;
      $display("txn %0d %s a=0x%08h b=0x%08h prod=0x%08h stall=%0d", txn, tag, ea, eb, malu, n);
   endtask

   logic [3:0] ops [15];

   initial begin
      ops = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd1, 4'd9, 4'd5, 4'd13, 4'd2, 4'd10,
              4'd6, 4'd14, 4'd3, 4'd7, 4'd15};
      clr = 1'b1;
      set_in(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      #1;
      check("rst_ctl", {29'd0, mwreg, mm2reg, mwmem}, 32'd0);
      check("rst_malu", malu, 32'd0);
      check("rst_mb", mb, 32'd0);
      check("rst_mrn", 32'(mrn), 32'd0);
      check("rst_estall", 32'(estall), 32'd0);

      // Directed add, sra, jal
      set_in(4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_single("add");
      check("add_12", malu, 32'd12);
      set_in(4'd15, 32'd0, 32'h80000000, 32'h00000100, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_single("sra");
      check("sra_f8", malu, 32'hF8000000);
      set_in(4'd0, 32'd1, 32'd2, 32'd0, 32'h100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_single("jal");
      check("jal_104", malu, 32'h104);

      // Directed multiplies, including back-to-back
      set_in(4'd11, 32'd7, 32'd6, 32'd0, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_mul("mul7x6");
      check("mul_42", malu, 32'd42);
      set_in(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_mul("mul_ff");
      check("mul_ff_1", malu, 32'd1);
      set_in(4'd11, 32'd3, 32'd3, 32'd0, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_mul("mul3x3");
      check("mul_9", malu, 32'd9);

      // Reset during BUSY aborts the multiply; a following add runs in one cycle
      set_in(4'd11, 32'd7, 32'd6, 32'd0, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy", 32'(estall), 32'd1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      set_in(4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("abort_ctl", {29'd0, mwreg, mm2reg, mwmem}, 32'd0);
      check("abort_malu", malu, 32'd0);
      check("abort_mb", mb, 32'd0);
      check("abort_mrn", 32'(mrn), 32'd0);
      run_single("post_abort_add");
      check("post_abort_12", malu, 32'd12);

      // Random single-cycle operations
      for (int i = 0; i < 150; i++) begin
         set_in(ops[$urandom_range(0, 14)], $urandom, $urandom, $urandom, $urandom,
                5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
         run_single("rnd");
      end

      // Random multiplies, back-to-back
      for (int i = 0; i < 4; i++) begin
         set_in(4'd11, $urandom, $urandom, $urandom, $urandom, 5'($urandom),
                1'($urandom), 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
         run_mul("rnd_mul");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
